final_dft_counter: RTL and testbench



---
 rtl/final_dft_pkg.sv | 11 +
 rtl/final_dft_counter_scan_dff.sv | 39 +++
 rtl/final_dft_counter.sv | 63 ++++++
 tb/tb_final_dft_counter.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/final_dft_pkg.sv
// Shared definitions for the scan-testable 3-bit counter.
// Counter width, reset value and the state vector type live here.
package final_dft_pkg;

    localparam int unsigned CNT_W = 3;

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t CNT_RST = 3'b000;

endpackage : final_dft_pkg

// File: rtl/final_dft_counter_scan_dff.sv
// Mux-D scan flip-flop: se=1 captures the serial scan input,
// se=0 captures the functional data input. Asynchronous active-low clear
// forces the flop to RST_VAL.
module scan_dff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic se,
    input  logic si,
    input  logic d,
    output logic q
);

    logic q_d;
    logic q_q;

    // Scan mux in front of the storage element.
    always_comb begin
        q_d = q_q;
        if (se) begin
            q_d = si;
        end else begin
            q_d = d;
        end
    end

    // State flop with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= RST_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule : scan_dff

// File: rtl/final_dft_counter.sv
// 3-bit up-counter built from scan flops.
// Functional mode counts modulo 8; shift mode turns the three state flops
// into a serial chain scan_in -> bit0 -> bit1 -> bit2 -> scan_out.
// Build option: define FINAL_DFT_SCAN_EN to enable the scan chain. Without
// it scan_en/scan_in are ignored, the block always counts and scan_out is 0.
module final_dft_counter
    import final_dft_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             scan_en,
    input  logic             scan_in,
    output logic [CNT_W-1:0] cnt,
    output logic             scan_out
);

    cnt_t cnt_q;
    cnt_t cnt_d;
    cnt_t scan_si_s;
    logic scan_se_s;

    // Next functional count, wrapping 7 -> 0 by natural overflow.
    always_comb begin
        cnt_d = cnt_q + 3'd1;
    end

`ifdef FINAL_DFT_SCAN_EN
    // Chain wiring: bit0 takes scan_in, each higher bit takes its lower neighbour.
    always_comb begin
        scan_se_s = scan_en;
        scan_si_s = {cnt_q[CNT_W-2:0], scan_in};
    end

    assign scan_out = cnt_q[CNT_W-1];
`else
    logic unused_scan_s;

    // Scan disabled: flops never select the shift path.
    always_comb begin
        scan_se_s = 1'b0;
        scan_si_s = CNT_RST;
    end

    assign unused_scan_s = scan_en ^ scan_in;
    assign scan_out      = 1'b0;
`endif

    for (genvar i = 0; i < CNT_W; i++) begin : g_bit
        scan_dff #(
            .RST_VAL (CNT_RST[i])
        ) u_scan_dff (
            .clk   (clk),
            .rst_n (rst_n),
            .se    (scan_se_s),
            .si    (scan_si_s[i]),
            .d     (cnt_d[i]),
            .q     (cnt_q[i])
        );
    end

    assign cnt = cnt_q;

endmodule : final_dft_counter

// File: tb/tb_final_dft_counter.sv
// Self-checking bench for final_dft_counter: a table of vectors with
// expected counts for both build options, a scoreboard queue, and
// hand-written asynchronous reset sequences.
module tb_final_dft_counter;
    import final_dft_pkg::*;

`ifdef FINAL_DFT_SCAN_EN
    localparam bit SCAN_ON = 1'b1;
`else
    localparam bit SCAN_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       scan_en;
    logic       scan_in;
    logic [2:0] cnt;
    logic       scan_out;

    final_dft_counter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .scan_en  (scan_en),
        .scan_in  (scan_in),
        .cnt      (cnt),
        .scan_out (scan_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       se;
        logic       si;
        logic [2:0] exp_on;
        logic [2:0] exp_off;
    } vec_t;

    typedef struct {
        int         idx;
        logic [2:0] exp_cnt;
        logic       exp_so;
    } sb_t;

    vec_t vecs[40];
    int   n_vecs = 0;
    sb_t  sb_q[$];
    int   n_applied = 0;
    int   n_miss = 0;

    function automatic void check(string name, logic [2:0] act_c, logic act_so,
                                  logic [2:0] exp_c, logic exp_so);
        n_applied++;
        if (act_c !== exp_c || act_so !== exp_so) begin
            n_miss++;
            $display("FAIL %s: got cnt=%b scan_out=%b, expected cnt=%b scan_out=%b",
                     name, act_c, act_so, exp_c, exp_so);
        end
    endfunction

    task automatic add(input logic se, input logic si,
                       input logic [2:0] on_v, input logic [2:0] off_v);
        vecs[n_vecs] = '{se: se, si: si, exp_on: on_v, exp_off: off_v};
        n_vecs++;
    endtask

    function automatic logic exp_scan_out(logic [2:0] c);
        return SCAN_ON ? c[2] : 1'b0;
    endfunction

    task automatic edge_check(string name, logic [2:0] exp_c);
        @(posedge clk);
        #1;
        check(name, cnt, scan_out, exp_c, exp_scan_out(exp_c));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        sb_t e;
        logic [2:0] ex;

        // Count 1..7, 0, 1 after reset release.
        add(1'b0, 1'b0, 3'd1, 3'd1);
        add(1'b0, 1'b0, 3'd2, 3'd2);
        add(1'b0, 1'b0, 3'd3, 3'd3);
        add(1'b0, 1'b0, 3'd4, 3'd4);
        add(1'b0, 1'b0, 3'd5, 3'd5);
        add(1'b0, 1'b0, 3'd6, 3'd6);
        add(1'b0, 1'b0, 3'd7, 3'd7);
        add(1'b0, 1'b0, 3'd0, 3'd0);
        add(1'b0, 1'b0, 3'd1, 3'd1);
        // Scan load 1,0,1 -> 101 (scan off: keeps counting).
        add(1'b1, 1'b1, 3'b011, 3'd2);
        add(1'b1, 1'b0, 3'b110, 3'd3);
        add(1'b1, 1'b1, 3'b101, 3'd4);
        // Load 011, then one functional edge -> 100.
        add(1'b1, 1'b0, 3'b010, 3'd5);
        add(1'b1, 1'b1, 3'b101, 3'd6);
        add(1'b1, 1'b1, 3'b011, 3'd7);
        add(1'b0, 1'b0, 3'b100, 3'd0);
        // Unload with scan_in=0: scan_out 1,0,0 before each edge, ends at 0.
        add(1'b1, 1'b0, 3'b000, 3'd1);
        add(1'b1, 1'b0, 3'b000, 3'd2);
        add(1'b1, 1'b0, 3'b000, 3'd3);
        // Load 111 then one functional edge wraps to 0.
        add(1'b1, 1'b1, 3'b001, 3'd4);
        add(1'b1, 1'b1, 3'b011, 3'd5);
        add(1'b1, 1'b1, 3'b111, 3'd6);
        add(1'b0, 1'b1, 3'b000, 3'd7);
        // Toggle mode on alternate edges.
        add(1'b1, 1'b1, 3'b001, 3'd0);
        add(1'b0, 1'b0, 3'b010, 3'd1);
        add(1'b1, 1'b0, 3'b100, 3'd2);

        rst_n   = 1'b0;
        scan_en = 1'b0;
        scan_in = 1'b0;
        #1;
        check("reset_no_clock", cnt, scan_out, 3'b000, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_held", cnt, scan_out, 3'b000, 1'b0);

        for (int i = 0; i < n_vecs; i++) begin
            @(negedge clk);
            rst_n   = 1'b1;
            scan_en = vecs[i].se;
            scan_in = vecs[i].si;
            ex      = SCAN_ON ? vecs[i].exp_on : vecs[i].exp_off;
            sb_q.push_back('{idx: i, exp_cnt: ex, exp_so: exp_scan_out(ex)});
            @(posedge clk);
            #1;
            if (sb_q.size() == 0) begin
                n_applied++;
                n_miss++;
                $display("FAIL scoreboard_empty at vec%0d", i);
            end else begin
                e = sb_q.pop_front();
                check($sformatf("vec%0d", e.idx), cnt, scan_out, e.exp_cnt, e.exp_so);
            end
        end

        // Asynchronous reset mid-count at cnt=5.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_assert", cnt, scan_out, 3'b000, 1'b0);
        @(negedge clk);
        rst_n   = 1'b1;
        scan_en = 1'b0;
        scan_in = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            edge_check($sformatf("recount%0d", k), 3'(k));
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_clear_at5", cnt, scan_out, 3'b000, 1'b0);
        edge_check("async_hold_low", 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        edge_check("release_first", 3'd1);
        edge_check("release_second", 3'd2);

        // Reset asserted while shifting in ones.
        @(negedge clk);
        scan_en = 1'b1;
        scan_in = 1'b1;
        edge_check("shift_then_rst", SCAN_ON ? 3'b101 : 3'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_during_shift", cnt, scan_out, 3'b000, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        edge_check("shift_after_rst", SCAN_ON ? 3'b001 : 3'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
        $finish;
    end

endmodule : tb_final_dft_counter
